// File: rtl/sg_pkg.sv
// Shared types for the scatter-gather element reader: element word layout,
// assembler state encoding and the queued element record.
package sg_pkg;

    localparam int ELEM_WORDS = 4;
    localparam int W_ADDR_LO  = 0;
    localparam int W_ADDR_HI  = 1;
    localparam int W_LEN      = 2;
    localparam int W_RSVD     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD2 = 2'd2
    } sg_state_e;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] len;
    } sg_elem_t;

    // Word W_RSVD is carried in the descriptor but never looked at.
    function automatic sg_elem_t decode_elem(input logic [ELEM_WORDS*32-1:0] i_words);
        sg_elem_t e;
        e.addr = {i_words[W_ADDR_HI*32 +: 32], i_words[W_ADDR_LO*32 +: 32]};
        e.len  = i_words[W_LEN*32 +: 32];
        return e;
    endfunction

endpackage

// File: rtl/sg_elem_fifo.sv
// First-word-fall-through element queue; pointers carry one extra wrap bit so
// full and empty are told apart without a counter.
module sg_elem_fifo #(
    parameter int C_WIDTH = 96,
    parameter int C_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_push,
    input  logic [C_WIDTH-1:0] i_data,
    input  logic               i_pop,
    output logic [C_WIDTH-1:0] o_data,
    output logic               o_empty,
    output logic               o_full
);

    localparam int AW = $clog2(C_DEPTH);
    localparam logic [AW:0] C_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [C_WIDTH-1:0] r_mem [C_DEPTH];
    logic               w_push;
    logic               w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    // Storage is not reset, so the head is masked to zero while empty.
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + C_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + C_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/sg_elem_reader.sv
// Assembles 128-bit SG descriptors from a FWFT beat stream into an element FIFO.
// Define SG_SKIP_ZERO_LEN_EN to consume but drop elements whose len is zero.
module sg_elem_reader
    import sg_pkg::*;
#(
    parameter int C_DATA_WIDTH = 128,
    parameter int C_ELEM_DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [C_DATA_WIDTH-1:0] SG_DATA,
    input  logic                    SG_DATA_EMPTY,
    output logic                    SG_DATA_REN,
    input  logic                    SG_RST,
    input  logic                    SG_ERR,
    output logic [63:0]             SG_ELEM_ADDR,
    output logic [31:0]             SG_ELEM_LEN,
    output logic                    SG_ELEM_RDY,
    input  logic                    SG_ELEM_REN,
    output logic                    SG_ELEM_ERR,
    output sg_state_e               o_dbg_state
);

    localparam bit         C_WIDE      = (C_DATA_WIDTH == 256);
    localparam int         C_BEATS     = C_WIDE ? 1 : (ELEM_WORDS * 32) / C_DATA_WIDTH;
    localparam logic [1:0] C_LAST_BEAT = 2'(C_BEATS - 1);

    sg_state_e    r_state;
    logic [1:0]   r_beat;
    logic [127:0] r_accum;
    logic         r_err;

    logic [127:0] w_lo;
    logic [127:0] w_hi;
    sg_elem_t     w_elem_lo;
    sg_elem_t     w_elem_hi;
    sg_elem_t     w_push_elem;
    sg_elem_t     w_head;
    logic         w_final;
    logic         w_permit;
    logic         w_pop_sg;
    logic         w_push;
    logic         w_full;
    logic         w_empty;
    logic         w_keep_lo;
    logic         w_keep_hi;

    // Narrow widths merge the current beat into the partial descriptor; at 256
    // bits one beat is two whole descriptors and r_accum parks the upper one.
    generate
        if (C_WIDE) begin : g_wide
            assign w_lo = SG_DATA[127:0];
            assign w_hi = SG_DATA[C_DATA_WIDTH-1:128];
        end else begin : g_narrow
            always_comb begin
                w_lo = r_accum;
                w_lo[r_beat*C_DATA_WIDTH +: C_DATA_WIDTH] = SG_DATA;
            end
            assign w_hi = '0;
        end
    endgenerate

    assign w_elem_lo = decode_elem(w_lo);
    assign w_elem_hi = decode_elem(w_hi);

`ifdef SG_SKIP_ZERO_LEN_EN
    assign w_keep_lo = (w_elem_lo.len != '0);
    assign w_keep_hi = (w_elem_hi.len != '0);
`else
    assign w_keep_lo = 1'b1;
    assign w_keep_hi = 1'b1;
`endif

    // A final beat is only taken when its element is guaranteed a FIFO slot.
    assign w_final     = (r_beat == C_LAST_BEAT);
    assign w_permit    = (r_state != HOLD2) && !(w_final && w_full);
    assign w_pop_sg    = !SG_DATA_EMPTY && !r_err && !SG_RST && !RST && w_permit;
    assign SG_DATA_REN = w_pop_sg;

    always_comb begin
        w_push      = 1'b0;
        w_push_elem = w_elem_lo;
        if (SG_RST) begin
            w_push = 1'b0;
        end else if (r_state == HOLD2) begin
            w_push      = !w_full;
            w_push_elem = decode_elem(r_accum);
        end else if (w_pop_sg && w_final) begin
            if (w_keep_lo) begin
                w_push = 1'b1;
            end else if (C_WIDE && w_keep_hi) begin
                w_push      = 1'b1;
                w_push_elem = w_elem_hi;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_accum <= '0;
            r_err   <= 1'b0;
        end else if (SG_RST) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (SG_ERR) r_err <= 1'b1;
            case (r_state)
                HOLD2: begin
                    if (!w_full) r_state <= IDLE;
                end
                default: begin
                    if (w_pop_sg) begin
                        if (w_final) begin
                            r_beat <= '0;
                            if (C_WIDE && w_keep_lo && w_keep_hi) begin
                                r_accum <= w_hi;
                                r_state <= HOLD2;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_beat  <= r_beat + 2'd1;
                            r_accum <= w_lo;
                            r_state <= ACCUM;
                        end
                    end
                end
            endcase
        end
    end

    sg_elem_fifo #(
        .C_WIDTH(96),
        .C_DEPTH(C_ELEM_DEPTH)
    ) u_fifo (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_clr  (SG_RST),
        .i_push (w_push),
        .i_data (w_push_elem),
        .i_pop  (SG_ELEM_REN && !SG_RST),
        .o_data (w_head),
        .o_empty(w_empty),
        .o_full (w_full)
    );

    assign SG_ELEM_ADDR = w_head.addr;
    assign SG_ELEM_LEN  = w_head.len;
    assign SG_ELEM_RDY  = !w_empty;
    assign SG_ELEM_ERR  = r_err;
    assign o_dbg_state  = r_state;

endmodule

// File: doc/sg_elem_reader.md
SG_ELEM_READER -- requirements
Module: sg_elem_reader

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 128; SG input width in bits, legal values 32/64/128/256.
REQ-002 SHALL have parameter C_ELEM_DEPTH, default 4; element FIFO entries, power of 2, at least 2.
REQ-003 SHALL have port CLK  in  1  single clock for all logic.
REQ-004 SHALL have port RST  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port SG_DATA  in  C_DATA_WIDTH  SG list data, first-word-fall-through, valid while SG_DATA_EMPTY=0.
REQ-006 SHALL have port SG_DATA_EMPTY  in  1  SG source empty.
REQ-007 SHALL have port SG_DATA_REN  out  1  pops one SG beat.
REQ-008 SHALL have port SG_RST  in  1  synchronous flush request.
REQ-009 SHALL have port SG_ERR  in  1  SG fetch error strobe.
REQ-010 SHALL have port SG_ELEM_ADDR  out  64  head element address.
REQ-011 SHALL have port SG_ELEM_LEN  out  32  head element length in 32-bit words.
REQ-012 SHALL have port SG_ELEM_RDY  out  1  head element valid.
REQ-013 SHALL have port SG_ELEM_REN  in  1  consumer pops head element.
REQ-014 SHALL have port SG_ELEM_ERR  out  1  sticky error flag.

Function
REQ-015 SHALL decode each element as 4 little-endian 32-bit words: w0 = addr[31:0], w1 = addr[63:32], w2 = len, w3 = reserved and ignored.
REQ-016 SHALL take 4/2/1 beats per element at 32/64/128 bits; at 256 bits one beat SHALL carry 2 elements, with the lower 128 bits first.
REQ-017 SHALL drive SG_DATA_REN = !SG_DATA_EMPTY && !SG_ELEM_ERR && !SG_RST && state permits a pop, as defined in REQ-018..020.
REQ-018 SHALL use assembler states IDLE, ACCUM and HOLD2.
- IDLE: waits for data.
- ACCUM: beat counter counts beats; advances only on a pop.
- HOLD2 (256-bit only): upper element still pending.
REQ-019 SHALL push an element into the FIFO in the cycle its final beat is popped; the final beat SHALL NOT be popped while the FIFO is registered-full, even if SG_ELEM_REN is asserted in the same cycle.
REQ-020 SHALL, at 256 bits, push the lower element on the pop cycle and enter HOLD2 if the upper element's push is blocked; HOLD2 SHALL push the upper element when not full, then return to IDLE; no pop SHALL occur in HOLD2.
REQ-021 SHALL give 1-cycle latency from the final-beat pop to SG_ELEM_RDY=1.
REQ-022 SHALL drive SG_ELEM_RDY = FIFO not empty, with SG_ELEM_ADDR/LEN showing the head entry (FWFT).
REQ-023 SHALL pop the head on SG_ELEM_REN && SG_ELEM_RDY; SG_ELEM_REN while RDY=0 SHALL be ignored.
REQ-024 SHALL apply a simultaneous push and pop when not full, with occupancy unchanged.
REQ-025 SHALL wrap FIFO pointers modulo C_ELEM_DEPTH, with full/empty distinguished by an extra pointer bit.
REQ-026 SHALL, on SG_ERR=1, set SG_ELEM_ERR in the next cycle, stop all pops, and keep already-queued elements poppable.
REQ-027 SHALL, on SG_RST=1, clear the assembler, FIFO and SG_ELEM_ERR by the next cycle, with SG_DATA_REN=0 during the SG_RST cycle; SG_RST SHALL take priority over SG_ERR and SG_ELEM_REN.

Reset
REQ-028 SHALL force on RST, asynchronously: state = IDLE, beat counter = 0, FIFO pointers = 0, SG_ELEM_RDY=0, SG_ELEM_ERR=0, SG_DATA_REN=0, SG_ELEM_ADDR/LEN=0.
REQ-029 SHALL discard any partially assembled element when RST is asserted mid-element.

Configuration
REQ-030 SHALL, with SG_SKIP_ZERO_LEN_EN defined, drop elements with len==0 without a push while still consuming their beats; without the macro, zero-length elements SHALL be queued like any other.

Structure
REQ-031 SHALL place in package sg_pkg: element word offsets (0..3), ELEM_WORDS=4, the assembler state enum, and a 96-bit element struct {addr[63:0], len[31:0]}.
REQ-032 SHALL implement the element FIFO as sub-module sg_elem_fifo (parameters: width 96, depth C_ELEM_DEPTH, FWFT).

Verification
REQ-033 SHALL cover: C_DATA_WIDTH=32, beats 0x1000, 0x0, 0x40, 0x0 -> RDY one cycle after the 4th pop; ADDR=0x1000, LEN=0x40.
REQ-034 SHALL cover: C_DATA_WIDTH=256, one beat carrying elements (A=0x2000, L=8) and (A=0x1_0000_3000, L=16), consumer popping every cycle -> two elements in order, 1 pop.
REQ-035 SHALL cover: depth 4, SG_ELEM_REN=0, 6 elements offered -> exactly 4 queued, SG_DATA_REN=0 on the 5th final beat; one REN pulse -> the 5th is accepted.
REQ-036 SHALL cover: SG_ERR pulse after 2 of 4 beats -> SG_ELEM_ERR=1, no further REN, queued elements still drain; SG_RST -> ERR=0, FIFO empty.
REQ-037 SHALL cover: RST asserted mid-element (after 1 of 2 beats at 64 bits), then a clean element -> only the clean element is output.
REQ-038 SHALL cover: len=0 element followed by len=5 -> with SG_SKIP_ZERO_LEN_EN only len=5 is output; without the macro both are output in order.
